pipe_stage_skid_reg: RTL and testbench

- Parametrised successor to the fixed inter-stage pipeline registers (IF/ID, ID/EXE, EXE/MEM, MEM/WB).
- Carries one packed payload word (datapath fields plus control enables) between two pipeline stages.
- Uses a valid/ready handshake and a 2-entry skid buffer, so upstream ready is registered and full throughput is kept under backpressure.
- Flush squashes in-flight entries into bubbles: control bits are forced to zero.

---
 rtl/pipe_stage_skid_reg.sv | 86 ++++++++
 tb/tb_pipe_stage_skid_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer and registered upstream ready.
// Flush turns held entries into bubbles by clearing their control-enable bits.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  // Ones in the control-enable LSBs; also works when CTRL_W == DATA_W.
  localparam logic [DATA_W-1:0] CTRL_MASK = ~({DATA_W{1'b1}} << CTRL_W);

  logic              m_valid_q, m_valid_d;
  logic              s_valid_q, s_valid_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_data_d  = m_data_q;
    s_data_d  = s_data_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      m_data_d  = m_data_q & ~CTRL_MASK;
      s_data_d  = s_data_q & ~CTRL_MASK;
    end else if (!m_valid_q) begin
      if (in_fire) begin
        m_valid_d = 1'b1;
        m_data_d  = in_data;
      end
    end else if (out_fire) begin
      // A full skid entry means in_ready is low, so no new beat competes here.
      if (s_valid_q) begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        m_data_d = in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      s_valid_d = 1'b1;
      s_data_d  = in_data;
    end
    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      m_data_q   <= '0;
      s_data_q   <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_valid_q ? m_data_q : (m_data_q & ~CTRL_MASK);
  assign occupancy = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Randomized and directed bench for pipe_stage_skid_reg, compared every cycle
// against a queue-based model of the stage's FIFO behaviour.
module tb_pipe_stage_skid_reg;

  localparam int DATA_W = 101;
  localparam int CTRL_W = 3;
  localparam logic [DATA_W-1:0] CTRL_MASK = ~({DATA_W{1'b1}} << CTRL_W);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  int checks = 0;
  int passes = 0;

  // Model: entries in arrival order, plus the word shown while empty.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] held = '0;
  bit                held_known = 1'b1;

  pipe_stage_skid_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[DATA_W-1:0];
  endfunction

  task automatic model_update();
    bit fin;
    bit fout;
    logic [DATA_W-1:0] v;
    if (rst) begin
      mq.delete();
      held = '0;
      held_known = 1'b1;
    end else if (flush) begin
      mq.delete();
      held_known = 1'b0;
    end else begin
      fin  = in_valid && (mq.size() < 2);
      fout = out_ready && (mq.size() > 0);
      if (fout) begin
        v = mq.pop_front();
        if (mq.size() == 0 && !fin) begin
          held = v;
          held_known = 1'b1;
        end
      end
      if (fin) mq.push_back(in_data);
    end
  endtask

  task automatic checkOutput();
    chk("out_valid", DATA_W'(out_valid), DATA_W'(mq.size() > 0));
    chk("occupancy", DATA_W'(occupancy), DATA_W'(mq.size()));
    chk("in_ready", DATA_W'(in_ready), DATA_W'(mq.size() < 2));
    if (mq.size() > 0) chk("out_data", out_data, mq[0]);
    else if (held_known) chk("out_data_idle", out_data, held & ~CTRL_MASK);
    else chk("out_ctrl_idle", DATA_W'(out_data[CTRL_W-1:0]), '0);
  endtask

  task automatic applyStimulus(input logic iv, input logic [DATA_W-1:0] d,
                               input logic ordy, input logic fl, input logic rs);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    @(posedge clk);
    model_update();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    logic [DATA_W-1:0] ones;
    ones = '1;

    // Reset held two cycles while upstream offers all-ones.
    applyStimulus(1'b1, ones, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, ones, 1'b0, 1'b0, 1'b1);
    chk("rst_in_ready", DATA_W'(in_ready), DATA_W'(1));
    chk("rst_out_valid", DATA_W'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_occupancy", DATA_W'(occupancy), '0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Streaming one beat per cycle.
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, DATA_W'(k), 1'b1, 1'b0, 1'b0);
      chk("stream_data", out_data, DATA_W'(k));
      chk("stream_occ", DATA_W'(occupancy), DATA_W'(1));
      chk("stream_ready", DATA_W'(in_ready), DATA_W'(1));
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure fills main then skid, then drains in order.
    applyStimulus(1'b1, DATA_W'('h11), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('h22), 1'b0, 1'b0, 1'b0);
    chk("bp_ready_low", DATA_W'(in_ready), '0);
    applyStimulus(1'b1, DATA_W'('h33), 1'b0, 1'b0, 1'b0);
    chk("bp_hold_11", out_data, DATA_W'('h11));
    chk("bp_occ2", DATA_W'(occupancy), DATA_W'(2));
    applyStimulus(1'b1, DATA_W'('h33), 1'b1, 1'b0, 1'b0);
    chk("bp_out_22", out_data, DATA_W'('h22));
    applyStimulus(1'b1, DATA_W'('h33), 1'b1, 1'b0, 1'b0);
    chk("bp_out_33", out_data, DATA_W'('h33));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Flush with a simultaneous input beat.
    applyStimulus(1'b1, DATA_W'('h107), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('h207), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('h307), 1'b0, 1'b1, 1'b0);
    chk("fl_out_valid", DATA_W'(out_valid), '0);
    chk("fl_ctrl", DATA_W'(out_data[CTRL_W-1:0]), '0);
    chk("fl_occ", DATA_W'(occupancy), '0);
    chk("fl_ready", DATA_W'(in_ready), DATA_W'(1));
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("fl_no_ghost", DATA_W'(out_valid), '0);

    // Stall with toggling upstream data.
    applyStimulus(1'b1, DATA_W'('hA1), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, DATA_W'('hA2), 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b1, rand_word(), 1'b0, 1'b0, 1'b0);
      chk("stall_data", out_data, DATA_W'('hA1));
      chk("stall_occ", DATA_W'(occupancy), DATA_W'(2));
    end

    // Reset and flush together while full, then a fresh beat.
    applyStimulus(1'b1, DATA_W'('hB5), 1'b0, 1'b1, 1'b1);
    chk("rf_out_data", out_data, '0);
    chk("rf_occ", DATA_W'(occupancy), '0);
    chk("rf_ready", DATA_W'(in_ready), DATA_W'(1));
    applyStimulus(1'b1, DATA_W'('h44), 1'b1, 1'b0, 1'b0);
    chk("rf_new_44", out_data, DATA_W'('h44));
    chk("rf_new_valid", DATA_W'(out_valid), DATA_W'(1));

    // Random traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), rand_word(),
                    1'($urandom_range(0, 2) != 0),
                    1'($urandom_range(0, 40) == 0),
                    1'($urandom_range(0, 150) == 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
